// File: rtl/mac_nibble_sched.sv
// Sequencer that forms a 16x16 unsigned MAC using one shared registered 4x4 multiplier.
// Define MAC_SEQ_SAT_EN to saturate the accumulator and enable the sticky out_ovf flag.
module mac_nibble_sched #(
    parameter int MUL_LAT = 2,
    parameter int ACC_W   = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic             in_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic [3:0]       mul_a,
    output logic [3:0]       mul_b,
    input  logic [7:0]       mul_p,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                       state_q, state_d;
    logic [15:0]                  a_q, a_d;
    logic [15:0]                  b_q, b_d;
    logic [3:0]                   k_q, k_d;
    logic [ACC_W-1:0]             acc_q, acc_d;
    logic [MUL_LAT-1:0]           vld_q, vld_d;
    logic [MUL_LAT-1:0][4:0]      shift_q, shift_d;

    logic                         accept;
    logic                         push;
    logic [4:0]                   issue_shift;
    logic                         pending;
    logic                         drain_done;
    logic [ACC_W-1:0]             addend;

    assign accept      = (state_q == IDLE) && in_valid;
    assign push        = (state_q == ISSUE);
    assign issue_shift = 5'({k_q[1:0], 2'b00}) + 5'({k_q[3:2], 2'b00});
    assign addend      = ACC_W'(mul_p) << shift_q[MUL_LAT-1];

    // Tags travel alongside the multiplier pipeline so each returning product knows its weight.
    always_comb begin
        vld_d      = '0;
        shift_d    = '0;
        vld_d[0]   = push;
        shift_d[0] = issue_shift;
        for (int i = 1; i < MUL_LAT; i++) begin
            vld_d[i]   = vld_q[i-1];
            shift_d[i] = shift_q[i-1];
        end
    end

    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < MUL_LAT - 1; i++) begin
            pending = pending | vld_q[i];
        end
        drain_done = vld_q[MUL_LAT-1] && !pending;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    k_d     = 4'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                k_d = k_q + 4'd1;
                if (k_q == 4'd15) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mul_a = 4'd0;
        mul_b = 4'd0;
        if (state_q == ISSUE) begin
            mul_a = a_q[{k_q[1:0], 2'b00} +: 4];
            mul_b = b_q[{k_q[3:2], 2'b00} +: 4];
        end
    end

`ifdef MAC_SEQ_SAT_EN
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, addend};

    // A carry out clamps to all-ones; later carries keep it pinned there.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (accept && in_clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (vld_q[MUL_LAT-1]) begin
            if (sum[ACC_W]) begin
                acc_d = '1;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = ovf_q;
`else
    always_comb begin
        acc_d = acc_q;
        if (accept && in_clr) begin
            acc_d = '0;
        end else if (vld_q[MUL_LAT-1]) begin
            acc_d = acc_q + addend;
        end
    end

    assign out_ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            vld_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            vld_q   <= vld_d;
            shift_q <= shift_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_acc   = acc_q;

endmodule

// File: tb/tb_mac_nibble_sched.sv
// Directed bench for mac_nibble_sched with a registered 4x4 multiplier model (ACC_W=32).
// Expected values for the wrap/saturate vectors follow MAC_SEQ_SAT_EN.
module tb_mac_nibble_sched;

    localparam int MUL_LAT = 2;
    localparam int ACC_W   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [15:0]       in_a = '0;
    logic [15:0]       in_b = '0;
    logic              in_clr = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ACC_W-1:0]  out_acc;
    logic              out_ovf;
    logic [3:0]        mul_a;
    logic [3:0]        mul_b;
    logic [7:0]        mul_p;
    logic              busy;

    logic [7:0]        p_pipe [MUL_LAT];

    int                checks = 0;
    int                errors = 0;
    int                lat;
    logic [63:0]       seq_a;
    logic [63:0]       seq_b;

    mac_nibble_sched #(.MUL_LAT(MUL_LAT), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_clr    (in_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Shared multiplier: product of the nibbles driven in cycle c appears in cycle c+MUL_LAT.
    always @(posedge clk) begin
        p_pipe[0] <= 8'(mul_a) * 8'(mul_b);
        for (int i = 1; i < MUL_LAT; i++) begin
            p_pipe[i] <= p_pipe[i-1];
        end
    end
    assign mul_p = p_pipe[MUL_LAT-1];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one operand pair, then records the issued nibbles and the cycles until out_valid.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic clr);
        int wait_cyc;
        lat      = 0;
        seq_a    = '0;
        seq_b    = '0;
        in_a     = a;
        in_b     = b;
        in_clr   = clr;
        in_valid = 1'b1;
        wait_cyc = 0;
        while (!in_ready && wait_cyc < 50) begin
            tick();
            wait_cyc++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        in_a     = 16'hDEAD;
        in_b     = 16'hBEEF;
        in_clr   = ~clr;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (cyc <= 16) begin
                seq_a[4*(cyc-1) +: 4] = mul_a;
                seq_b[4*(cyc-1) +: 4] = mul_b;
            end
            if (out_valid) begin
                lat = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic releaseResult();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("release_valid", 64'(out_valid), 64'd0);
        checkOutput("release_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stray;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_acc", 64'(out_acc), 64'd0);
        checkOutput("rst_mul_ab", {56'd0, mul_a, mul_b}, 64'd0);
        checkOutput("rst_ovf", 64'(out_ovf), 64'd0);

        applyStimulus(16'h0003, 16'h0005, 1'b1);
        checkOutput("t1_latency", 64'(lat), 64'd19);
        checkOutput("t1_acc", 64'(out_acc), 64'd15);
        checkOutput("t1_seq_a", seq_a, 64'h0003000300030003);
        checkOutput("t1_seq_b", seq_b, 64'h0000000000005555);
        checkOutput("t1_done_ready", 64'(in_ready), 64'd0);
        checkOutput("t1_done_busy", 64'(busy), 64'd1);
        checkOutput("t1_done_mul_ab", {56'd0, mul_a, mul_b}, 64'd0);
        releaseResult();

        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
        checkOutput("t2_acc", 64'(out_acc), 64'hFFFE0001);
        releaseResult();

        applyStimulus(16'h1234, 16'h5678, 1'b1);
        checkOutput("t3_acc", 64'(out_acc), 64'h06260060);
        checkOutput("t3_seq_a", seq_a, 64'h1234123412341234);
        checkOutput("t3_seq_b", seq_b, 64'h5555666677778888);
        releaseResult();

        applyStimulus(16'h0002, 16'h0003, 1'b0);
        checkOutput("t4_acc", 64'(out_acc), 64'h06260066);
        checkOutput("t4_latency", 64'(lat), 64'd19);

        // Hold the result while a new operand pair is already waiting.
        in_a     = 16'h0007;
        in_b     = 16'h0009;
        in_clr   = 1'b1;
        in_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            checkOutput("bp_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_acc", 64'(out_acc), 64'h06260066);
            checkOutput("bp_ready", 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp_exit_valid", 64'(out_valid), 64'd0);
        checkOutput("bp_exit_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("bp_accept_busy", 64'(busy), 64'd1);
        checkOutput("bp_k0_mul_ab", {56'd0, mul_a, mul_b}, 64'h79);
        for (int n = 0; n < 8; n++) begin
            tick();
        end
        checkOutput("k8_mul_ab", {56'd0, mul_a, mul_b}, 64'h70);

        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_mul_ab", {56'd0, mul_a, mul_b}, 64'd0);
        checkOutput("midrst_acc", 64'(out_acc), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (out_valid) stray++;
        end
        checkOutput("midrst_no_valid", 64'(stray), 64'd0);

        applyStimulus(16'h0007, 16'h0009, 1'b1);
        checkOutput("t5_acc", 64'(out_acc), 64'd63);
        checkOutput("t5_latency", 64'(lat), 64'd19);
        releaseResult();

        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
        checkOutput("w1_acc", 64'(out_acc), 64'hFFFE0001);
        checkOutput("w1_ovf", 64'(out_ovf), 64'd0);
        releaseResult();

        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0);
`ifdef MAC_SEQ_SAT_EN
        checkOutput("w2_acc", 64'(out_acc), 64'hFFFFFFFF);
        checkOutput("w2_ovf", 64'(out_ovf), 64'd1);
`else
        checkOutput("w2_acc", 64'(out_acc), 64'hFFFC0002);
        checkOutput("w2_ovf", 64'(out_ovf), 64'd0);
`endif
        releaseResult();

        applyStimulus(16'h0001, 16'h0001, 1'b0);
`ifdef MAC_SEQ_SAT_EN
        checkOutput("w3_acc", 64'(out_acc), 64'hFFFFFFFF);
        checkOutput("w3_ovf", 64'(out_ovf), 64'd1);
`else
        checkOutput("w3_acc", 64'(out_acc), 64'hFFFC0003);
        checkOutput("w3_ovf", 64'(out_ovf), 64'd0);
`endif
        releaseResult();

        applyStimulus(16'h0001, 16'h0001, 1'b1);
        checkOutput("w4_acc", 64'(out_acc), 64'd1);
        checkOutput("w4_ovf", 64'(out_ovf), 64'd0);
        releaseResult();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
